// File: rtl/mac_lookup_header_parser.sv
// mac_lookup_header_parser: parses Ethernet header words into one MAC table lookup per frame and aligns the result into a forwarding decision.
// Optional counters stat_hits/stat_misses/stat_runts are enabled by MAC_LOOKUP_STATS_EN.
module mac_lookup_header_parser #(
  parameter logic [4:0]  PORT_NUM       = 5'd0,
  parameter logic [11:0] DEFAULT_VLAN   = 12'd1,
  parameter int          LOOKUP_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_frame_start,
  input  logic        rx_frame_data_valid,
  input  logic [31:0] rx_frame_data,
  input  logic        rx_frame_commit,
  input  logic        rx_frame_drop,
  output logic        lookup_en,
  output logic [11:0] lookup_src_vlan,
  output logic [47:0] lookup_src_mac,
  output logic [4:0]  lookup_src_port,
  output logic [47:0] lookup_dst_mac,
  input  logic        lookup_hit,
  input  logic [4:0]  lookup_dst_port,
  output logic        fwd_valid,
  output logic        fwd_flood,
  output logic        fwd_drop,
  output logic [4:0]  fwd_dst_port,
  output logic [11:0] fwd_vlan
`ifdef MAC_LOOKUP_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_runts
`endif
);
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR3, BODY} state_t;
  state_t state, state_nxt;
  logic [47:0] dst, src;
  logic [11:0] vid, vlan;
  logic req, fin, take_start, valid, flood;
  logic [14:0] ctx [LOOKUP_LATENCY];
  logic [14:0] tail;
  assign valid = rx_frame_data_valid;
  assign fin = rx_frame_commit | rx_frame_drop;
  assign take_start = valid & rx_frame_start;
  assign vid = rx_frame_data[11:0];
  assign vlan = (rx_frame_data[31:16] == 16'h8100 && vid != 12'd0) ? vid : DEFAULT_VLAN;
  assign lookup_src_port = PORT_NUM;
  always_comb begin
    state_nxt = state;
    req = 1'b0;
    if (take_start) state_nxt = fin ? IDLE : HDR1;
    else case (state)
      HDR1, HDR2: state_nxt = fin ? IDLE : !valid ? state : (state == HDR1) ? HDR2 : HDR3;
      HDR3: begin
        req = valid;
        state_nxt = fin ? IDLE : valid ? BODY : HDR3;
      end
      BODY: state_nxt = fin ? IDLE : BODY;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dst <= '0;
      src <= '0;
      lookup_en <= 1'b0;
      lookup_src_vlan <= '0;
      lookup_src_mac <= '0;
      lookup_dst_mac <= '0;
    end else begin
      state <= state_nxt;
      lookup_en <= req;
      if (take_start) dst[47:16] <= rx_frame_data;
      else if (valid && state == HDR1) {dst[15:0], src[47:32]} <= rx_frame_data;
      else if (valid && state == HDR2) src[31:0] <= rx_frame_data;
      if (req) begin
        lookup_src_vlan <= vlan;
        lookup_src_mac <= src;
        lookup_dst_mac <= dst;
      end
    end
  end
  // Context entry {valid, multicast, broadcast, vlan} travels alongside the table latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LOOKUP_LATENCY; i++) ctx[i] <= '0;
    end else begin
      ctx[0] <= lookup_en ? {1'b1, lookup_dst_mac[40], &lookup_dst_mac, lookup_src_vlan} : '0;
      for (int i = 1; i < LOOKUP_LATENCY; i++) ctx[i] <= ctx[i-1];
    end
  end
  assign tail = ctx[LOOKUP_LATENCY-1];
  assign flood = tail[14] & (tail[13] | tail[12] | !lookup_hit);
  assign fwd_valid = tail[14];
  assign fwd_flood = flood;
  assign fwd_drop = tail[14] & !flood & (lookup_dst_port == PORT_NUM);
  assign fwd_dst_port = (tail[14] & !flood & !fwd_drop) ? lookup_dst_port : '0;
  assign fwd_vlan = tail[11:0];
`ifdef MAC_LOOKUP_STATS_EN
  logic runt, uni;
  assign runt = fin & (take_start | state == HDR1 | state == HDR2 | (state == HDR3 & !valid));
  assign uni = tail[14] & !tail[13] & !tail[12];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits <= '0;
      stat_misses <= '0;
      stat_runts <= '0;
    end else begin
      if (uni && lookup_hit && stat_hits != 16'hffff) stat_hits <= stat_hits + 16'd1;
      if (uni && !lookup_hit && stat_misses != 16'hffff) stat_misses <= stat_misses + 16'd1;
      if (runt && stat_runts != 16'hffff) stat_runts <= stat_runts + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_lookup_header_parser.sv
// tb_mac_lookup_header_parser: directed frames, a MAC table responder and a per-cycle decision scoreboard.
module tb_mac_lookup_header_parser;
  localparam int L = 8;
  localparam logic [4:0] PN = 5'd12;
  logic clk = 1'b0, rst_n;
  logic rx_frame_start, rx_frame_data_valid, rx_frame_commit, rx_frame_drop;
  logic [31:0] rx_frame_data;
  logic lookup_en, lookup_hit, fwd_valid, fwd_flood, fwd_drop;
  logic [11:0] lookup_src_vlan, fwd_vlan;
  logic [47:0] lookup_src_mac, lookup_dst_mac;
  logic [4:0] lookup_src_port, lookup_dst_port, fwd_dst_port;

  mac_lookup_header_parser #(.PORT_NUM(PN), .DEFAULT_VLAN(12'd1), .LOOKUP_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .rx_frame_start(rx_frame_start), .rx_frame_data_valid(rx_frame_data_valid),
    .rx_frame_data(rx_frame_data), .rx_frame_commit(rx_frame_commit), .rx_frame_drop(rx_frame_drop),
    .lookup_en(lookup_en), .lookup_src_vlan(lookup_src_vlan), .lookup_src_mac(lookup_src_mac),
    .lookup_src_port(lookup_src_port), .lookup_dst_mac(lookup_dst_mac), .lookup_hit(lookup_hit),
    .lookup_dst_port(lookup_dst_port), .fwd_valid(fwd_valid), .fwd_flood(fwd_flood), .fwd_drop(fwd_drop),
    .fwd_dst_port(fwd_dst_port), .fwd_vlan(fwd_vlan));

  always #5 clk = ~clk;

  typedef struct {int c; logic [47:0] d; logic [47:0] s; logic [11:0] v; logic h; logic [4:0] p;} req_t;
  req_t q[$];
  req_t cur;
  logic [18:0] ef [int];
  logic [5:0] rs [int];
  int cyc = 0, n_chk = 0, n_fail = 0, n_lk = 0, n_fwd = 0, k = 0;
  int ll_c = 0, lf_c = 0;
  logic [47:0] ll_src = '0, ll_dst = '0;
  logic [11:0] ll_vlan = '0, lf_vlan = '0;
  logic lf_flood = 1'b0, lf_drop = 1'b0;
  logic [4:0] lf_port = '0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Forwarding rules: group/broadcast or miss floods, hit on own port is a hairpin drop.
  function automatic logic [18:0] decide(input logic [47:0] d, input logic h, input logic [4:0] p, input logic [11:0] v);
    logic fl, dr;
    fl = d[40] | (d == {48{1'b1}}) | !h;
    dr = !fl && p == PN;
    return {fl, dr, p, v};
  endfunction

  // MAC table: answers L cycles after each request; otherwise drives junk with hit set.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    lookup_hit = rs.exists(cyc) ? rs[cyc][5] : 1'b1;
    lookup_dst_port = rs.exists(cyc) ? rs[cyc][4:0] : 5'(cyc);
  end

  always @(negedge clk) if (rst_n) begin
    if (lookup_en) begin
      n_lk++;
      ll_c = cyc; ll_src = lookup_src_mac; ll_dst = lookup_dst_mac; ll_vlan = lookup_src_vlan;
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lookup_spurious: lookup_en=1 at cycle %0d, required 0", cyc);
      end else begin
        cur = q.pop_front();
        chk("lookup_cycle", cyc, cur.c);
        chk("lookup_dst_mac", lookup_dst_mac, cur.d);
        chk("lookup_src_mac", lookup_src_mac, cur.s);
        chk("lookup_src_vlan", lookup_src_vlan, cur.v);
        chk("lookup_src_port", lookup_src_port, PN);
        rs[cyc+L] = {cur.h, cur.p};
        ef[cyc+L] = decide(cur.d, cur.h, cur.p, cur.v);
      end
    end
    if (ef.exists(cyc)) begin
      chk("fwd_valid", fwd_valid, 1);
      chk("fwd_flood", fwd_flood, ef[cyc][18]);
      chk("fwd_drop", fwd_drop, ef[cyc][17]);
      if (!ef[cyc][18] && !ef[cyc][17]) chk("fwd_dst_port", fwd_dst_port, ef[cyc][16:12]);
      chk("fwd_vlan", fwd_vlan, ef[cyc][11:0]);
      ef.delete(cyc);
    end else chk("fwd_idle", {fwd_valid, fwd_flood, fwd_drop}, 3'b000);
    if (fwd_valid) begin
      n_fwd++;
      lf_c = cyc; lf_flood = fwd_flood; lf_drop = fwd_drop; lf_port = fwd_dst_port; lf_vlan = fwd_vlan;
    end
  end

  task automatic drive(input logic s, input logic v, input logic [31:0] w, input logic c, input logic dr);
    @(posedge clk);
    #1;
    rx_frame_start = s; rx_frame_data_valid = v; rx_frame_data = w; rx_frame_commit = c; rx_frame_drop = dr;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 32'h0, 0, 0);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic frame(input logic [47:0] d, input logic [47:0] s, input logic tg, input logic [15:0] tci,
                       input logic h, input logic [4:0] p, input int body, input logic gap);
    logic [31:0] w [4];
    req_t r;
    int n;
    w[0] = d[47:16]; w[1] = {d[15:0], s[47:32]}; w[2] = s[31:0];
    w[3] = tg ? {16'h8100, tci} : 32'h08004500;
    n = 4 + body;
    for (int i = 0; i < n; i++) begin
      if (gap && i == 2) drive(0, 0, 32'h0, 0, 0);
      drive(i == 0, 1, (i < 4) ? w[i & 3] : 32'h5a5a0000 + 32'(i), i == n - 1, 0);
      if (i == 3) begin
        r.c = cyc + 1; r.d = d; r.s = s; r.v = (tg && tci[11:0] != 12'd0) ? tci[11:0] : 12'd1; r.h = h; r.p = p;
        q.push_back(r);
      end
    end
  endtask

  task automatic partial(input logic [47:0] d, input logic [47:0] s, input int n, input int endk);
    logic [31:0] w [3];
    w[0] = d[47:16]; w[1] = {d[15:0], s[47:32]}; w[2] = s[31:0];
    for (int i = 0; i < n; i++) drive(i == 0, 1, w[i % 3], endk == 1 && i == n - 1, endk == 2 && i == n - 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete(); ef.delete(); rs.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lookup_en", lookup_en, 0);
    chk("rst_src_mac", lookup_src_mac, 0);
    chk("rst_dst_mac", lookup_dst_mac, 0);
    chk("rst_vlan", lookup_src_vlan, 0);
    chk("rst_src_port", lookup_src_port, PN);
    chk("rst_fwd", {fwd_valid, fwd_flood, fwd_drop, fwd_dst_port, fwd_vlan}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_frame_start = 0; rx_frame_data_valid = 0; rx_frame_data = 0; rx_frame_commit = 0; rx_frame_drop = 0;
    lookup_hit = 0; lookup_dst_port = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_lookup_en", lookup_en, 0);
    chk("reset_src_port", lookup_src_port, PN);
    chk("reset_src_mac", lookup_src_mac, 0);
    chk("reset_fwd", {fwd_valid, fwd_flood, fwd_drop}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // untagged unicast, table miss
    frame(48'h02deadbeef0a, 48'h02deadbeef0c, 0, 16'h0, 0, 5'd3, 2, 0);
    idle(L + 4);
    chk("t1_dst_mac", ll_dst, 48'h02deadbeef0a);
    chk("t1_src_mac", ll_src, 48'h02deadbeef0c);
    chk("t1_vlan", ll_vlan, 12'd1);
    chk("t1_flood", lf_flood, 1);
    chk("t1_latency", lf_c - ll_c, 8);
    chk("t1_nfwd", n_fwd, 1);
    // tagged VID 2, hit on port 0x0a, with a valid bubble in the header
    frame(48'h001122334455, 48'h02aabbccddee, 1, 16'h0002, 1, 5'h0a, 1, 1);
    idle(L + 4);
    chk("t2_port", lf_port, 5'h0a);
    chk("t2_vlan", lf_vlan, 12'd2);
    chk("t2_flood_drop", {lf_flood, lf_drop}, 2'b00);
    // hairpin
    frame(48'h001122334466, 48'h02aabbccddee, 1, 16'h2005, 1, 5'd12, 0, 0);
    idle(L + 4);
    chk("t3_drop", {lf_flood, lf_drop}, 2'b01);
    chk("t3_vlan", lf_vlan, 12'd5);
    // broadcast with hit
    frame(48'hffffffffffff, 48'h02aabbccddee, 0, 16'h0, 1, 5'h0a, 0, 0);
    idle(L + 4);
    chk("t4_bcast_flood", {lf_flood, lf_drop}, 2'b10);
    // multicast with hit, tag with VID 0
    frame(48'h01005e000001, 48'h02aabbccddee, 1, 16'h6000, 1, 5'h03, 0, 0);
    idle(L + 4);
    chk("t5_mcast_flood", lf_flood, 1);
    chk("t5_vid0_vlan", lf_vlan, 12'd1);
    // runts: commit after 2 words, drop after 3
    k = n_lk;
    partial(48'h001122334455, 48'h02aabbccddee, 2, 1);
    idle(2);
    partial(48'h001122334455, 48'h02aabbccddee, 3, 2);
    idle(L + 4);
    chk("runt_no_lookup", n_lk, k);
    chk("runt_no_fwd", n_fwd, 5);
    // restart mid-header
    partial(48'h00aaaaaaaaaa, 48'h02bbbbbbbbbb, 3, 0);
    frame(48'h00cccccccccc, 48'h02dddddddddd, 1, 16'h0007, 1, 5'd4, 0, 0);
    idle(L + 4);
    chk("restart_one_lookup", n_lk, k + 1);
    chk("restart_src", ll_src, 48'h02dddddddddd);
    chk("restart_port", lf_port, 5'd4);
    // back-to-back minimum frames
    k = n_fwd;
    frame(48'h000000000101, 48'h020000000001, 1, 16'h0011, 1, 5'd1, 0, 0);
    frame(48'h000000000202, 48'h020000000002, 1, 16'h0022, 0, 5'd1, 0, 0);
    idle(L + 4);
    chk("b2b_nfwd", n_fwd, k + 2);
    chk("b2b_vlan", lf_vlan, 12'h022);
    chk("b2b_flood", lf_flood, 1);
    // reset between request and result
    k = n_fwd;
    frame(48'h000000000303, 48'h020000000003, 0, 16'h0, 1, 5'd2, 0, 0);
    idle(2);
    reset_pulse();
    idle(L + 4);
    chk("rst_no_fwd", n_fwd, k);
    frame(48'h000000000404, 48'h020000000004, 0, 16'h0, 1, 5'd6, 0, 0);
    idle(L + 4);
    chk("post_rst_fwd", n_fwd, k + 1);
    chk("post_rst_port", lf_port, 5'd6);
    chk("pending_requests", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_lookup_header_parser.md
Name: mac_lookup_header_parser

Overview:
Per-port ingress stage that sits directly upstream of the MAC address table. It parses the first 16 bytes of each received Ethernet frame from a 32-bit stream and issues one lookup request per frame, carrying dst/src MAC, VLAN and ingress port. It then aligns the table's fixed-latency result with per-frame context and emits a forwarding decision for the port's frame buffer/crossbar logic.

Parameters:
PORT_NUM, 0, 5-bit ingress port number driven on lookup_src_port.
DEFAULT_VLAN, 1, 12-bit VLAN for untagged frames.
LOOKUP_LATENCY, 3, cycles from lookup_en to valid lookup_hit/lookup_dst_port (1 to 8).

Ports:
clk  in  1  core clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
rx_frame_start  in  1  first-word strobe, coincident with the first valid word.
rx_frame_data_valid  in  1  rx_frame_data valid this cycle.
rx_frame_data  in  32  frame bytes, big-endian (first byte in [31:24]).
rx_frame_commit  in  1  end of good frame.
rx_frame_drop  in  1  end of bad frame (FCS/length error).
lookup_en  out  1  one-cycle lookup request to MAC table.
lookup_src_vlan  out  12  VLAN of request.
lookup_src_mac  out  48  source MAC.
lookup_src_port  out  5  always PORT_NUM.
lookup_dst_mac  out  48  destination MAC.
lookup_hit  in  1  table result, valid LOOKUP_LATENCY cycles after lookup_en.
lookup_dst_port  in  5  port for lookup_hit.
fwd_valid  out  1  one-cycle decision strobe.
fwd_flood  out  1  flood to all ports in fwd_vlan except PORT_NUM.
fwd_drop  out  1  discard frame (hairpin).
fwd_dst_port  out  5  unicast egress port, valid when !fwd_flood && !fwd_drop.
fwd_vlan  out  12  VLAN of decision.

Behaviour:
- Reset: all outputs 0 except lookup_src_port = PORT_NUM; FSM IDLE; context pipeline cleared.
- Header FSM advances only on rx_frame_data_valid. IDLE -(start)-> capture word0 = dst[47:16] -> HDR1 (word1: dst[15:0], src[47:32]) -> HDR2 (src[31:0]) -> HDR3 (word3) -> BODY.
- HDR3: word3[31:16] == 16'h8100 -> vlan = word3[11:0]; else vlan = DEFAULT_VLAN. Tag with VID 0 treated as DEFAULT_VLAN.
- lookup_en asserted the cycle after word3 is accepted; request fields registered and held until the next request.
- BODY: wait for commit or drop -> IDLE. Commit/drop in same cycle as word3 still issues lookup.
- Runt: commit or drop before word3 -> no lookup, no fwd_valid, -> IDLE.
- rx_frame_start while not IDLE: abandon current header (no lookup if not yet issued), restart capture with this word.
- Context pipeline: LOOKUP_LATENCY-deep shift register carrying {valid, dst multicast bit dst[40], dst==FF:FF:FF:FF:FF:FF, vlan}; entry injected with lookup_en. Back-to-back requests every cycle supported (minimum frame gives one per 4 cycles anyway).
- At pipeline output (exactly LOOKUP_LATENCY cycles after lookup_en): fwd_valid=1, fwd_vlan=ctx.vlan.
  - broadcast or multicast -> fwd_flood=1, lookup_hit ignored.
  - else !lookup_hit -> fwd_flood=1.
  - else lookup_dst_port == PORT_NUM -> fwd_drop=1.
  - else fwd_dst_port = lookup_dst_port.
- fwd_flood and fwd_drop are never both 1; both 0 whenever fwd_valid=0.
- Reset mid-frame or mid-pipeline: in-flight contexts discarded; no fwd_valid after reset for pre-reset requests.

Optional Feature:
MAC_LOOKUP_STATS_EN: defined -> adds outputs stat_hits, stat_misses, stat_runts (16 bits each), saturating at 16'hffff, cleared by rst_n; hits/misses count unicast decisions only (hairpin counts as hit). Undefined -> ports and counters absent; behaviour otherwise identical.

Test Plan:
- Untagged unicast dst 02:de:ad:be:ef:0a, src 02:de:ad:be:ef:0c, PORT_NUM=12, table miss -> lookup_en once, vlan=1, src_port=0x0c; LOOKUP_LATENCY cycles later fwd_valid, fwd_flood=1.
- Tagged frame TPID 8100 TCI 0x0002, table hit port 0x0a -> fwd_dst_port=0x0a, fwd_vlan=2, flood=0, drop=0.
- Hit returning port 0x0c on PORT_NUM=12 -> fwd_drop=1; broadcast dst with hit=1 -> fwd_flood=1.
- Frame committed after 2 words -> no lookup_en, no fwd_valid (stat_runts=1 when stats on).
- Two 4-word frames back-to-back with LOOKUP_LATENCY=8 -> two fwd_valid strobes, each exactly 8 cycles after its lookup_en, with correct per-frame VLAN.
- rst_n low for 1 cycle between lookup_en and result -> no fwd_valid for that request; outputs at reset values.
